key_sender: RTL

- Transmitter end of the one-hot tenkey interface used by the electronic-lock block.
- Accepts a packed multi-digit code through a valid/ready handshake and replays it as one-hot `tenkey` pulses, one digit per slot, in the order a human keypad would produce them.
- Used for remote/automated entry and as the stimulus source for lock verification.

---
 rtl/key_sender.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/key_sender.sv
// One-hot tenkey transmitter: captures a packed BCD code via start/ready and replays it digit by digit.
// Optional KEY_SENDER_CLOSE_EN inserts a one-cycle close strobe before the first digit.
module key_sender #(
  parameter int DIGITS   = 4,
  parameter int HOLD_CYC = 1,
  parameter int GAP_CYC  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   code,
  input  logic                  abort,
  output logic                  ready,
  output logic                  busy,
  output logic [9:0]            tenkey,
  output logic                  close,
  output logic                  done,
  output logic                  err
);

  localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAXV   = (MAX_HG > DIGITS) ? MAX_HG : DIGITS;
  localparam int CW     = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam int GAP_M1 = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_M1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef KEY_SENDER_CLOSE_EN
    S_CLOSE = 3'd1,
`endif
    S_HOLD  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [4*DIGITS-1:0]   shift_reg, shift_next;
  logic [CW-1:0]         idx_reg, idx_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [9:0]            tenkey_reg, tenkey_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  busy_reg, busy_next;
  logic                  ready_reg, ready_next;
  logic [DIGITS-1:0]     digit_bad;
  logic                  code_bad;

  // Any non-BCD digit rejects the whole request.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_check
      assign digit_bad[gi] = (code[4*gi+3 -: 4] > 4'd9);
    end
  endgenerate
  assign code_bad = |digit_bad;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (code_bad) begin
            err_next = 1'b1;
          end else begin
            shift_next = code;
            idx_next   = '0;
            cnt_next   = '0;
`ifdef KEY_SENDER_CLOSE_EN
            state_next = S_CLOSE;
`else
            state_next = S_HOLD;
`endif
          end
        end
      end
`ifdef KEY_SENDER_CLOSE_EN
      S_CLOSE: begin
        cnt_next   = '0;
        state_next = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cnt_next = '0;
          if (idx_reg == DIGIT_LAST) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            shift_next = shift_reg >> 4;
            state_next = (GAP_CYC > 0) ? S_GAP : S_HOLD;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    tenkey_next = (state_next == S_HOLD) ? (10'b1 << shift_next[3:0]) : 10'b0;
    done_next   = (state_next == S_DONE);
    busy_next   = (state_next != S_IDLE);
    ready_next  = (state_next == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      shift_reg  <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      tenkey_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      tenkey_reg <= tenkey_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      busy_reg   <= busy_next;
      ready_reg  <= ready_next;
    end
  end

`ifdef KEY_SENDER_CLOSE_EN
  logic close_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) close_reg <= 1'b0;
    else        close_reg <= (state_next == S_CLOSE);
  end
  assign close = close_reg;
`else
  assign close = 1'b0;
`endif

  assign tenkey = tenkey_reg;
  assign done   = done_reg;
  assign err    = err_reg;
  assign busy   = busy_reg;
  assign ready  = ready_reg;

endmodule
